// File: rtl/inst_sram_axi_bridge.sv
// Instruction sram-like responder bridged onto AXI read channels (single-beat, read-only).
// One AR holding register plus an outstanding counter bounds the requests in flight.
module inst_sram_axi_bridge #(
    parameter int unsigned OUTSTANDING = 2,
    parameter logic [3:0]  ARID_VAL    = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [31:0] inst_sram_addr,
    output logic        inst_sram_addr_ok,
    output logic [31:0] inst_sram_rdata,
    output logic        inst_sram_data_ok,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);
    localparam int CW = $clog2(OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(OUTSTANDING);

    logic          arvalid_q, arvalid_d;
    logic [31:0]   araddr_q, araddr_d;
    logic [2:0]    arsize_q, arsize_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Single in-order ID: rid and rresp carry nothing this bridge acts on.
    logic unused_sigs;
    assign unused_sigs = ^{rid, rresp};

    assign inst_sram_addr_ok = inst_sram_req && !inst_sram_wr && !arvalid_q && (cnt_q < MAX_CNT);
    // Guarding on cnt drops R beats nobody asked for (e.g. left over from a reset).
    assign inst_sram_data_ok = rvalid && rlast && (cnt_q != '0);
    assign inst_sram_rdata   = rdata;

    assign arid    = ARID_VAL;
    assign araddr  = araddr_q;
    assign arsize  = arsize_q;
    assign arvalid = arvalid_q;
    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign rready  = 1'b1;

    always_comb begin
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        arsize_d  = arsize_q;
        cnt_d     = cnt_q;
        if (arvalid_q && arready)
            arvalid_d = 1'b0;
        if (inst_sram_addr_ok) begin
            arvalid_d = 1'b1;
            araddr_d  = inst_sram_addr;
            arsize_d  = {1'b0, inst_sram_size};
        end
        case ({inst_sram_addr_ok, inst_sram_data_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            arvalid_q <= 1'b0;
            araddr_q  <= 32'd0;
            arsize_q  <= 3'd0;
            cnt_q     <= '0;
        end else begin
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            arsize_q  <= arsize_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule

// File: tb/tb_inst_sram_axi_bridge.sv
// Directed scenarios for inst_sram_axi_bridge; expected read data queued on accept, popped on data_ok.
module tb_inst_sram_axi_bridge;
    logic        clk = 1'b0;
    logic        reset;
    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic        addr_ok, data_ok;
    logic [31:0] sram_rdata;
    logic [3:0]  arid, rid;
    logic [31:0] araddr, rdata;
    logic [7:0]  arlen;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, arlock, rresp;
    logic [3:0]  arcache;
    logic        arvalid, arready, rlast, rvalid, rready;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    inst_sram_axi_bridge #(.OUTSTANDING(2), .ARID_VAL(4'd0)) dut (
        .clk(clk), .reset(reset),
        .inst_sram_req(req), .inst_sram_wr(wr), .inst_sram_size(size), .inst_sram_addr(addr),
        .inst_sram_addr_ok(addr_ok), .inst_sram_rdata(sram_rdata), .inst_sram_data_ok(data_ok),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; checks happen 1ns later, well clear of posedge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        req = 1'b0; wr = 1'b0; size = 2'd2; addr = 32'd0;
        arready = 1'b1; rvalid = 1'b0; rlast = 1'b0; rdata = 32'd0; rid = 4'd0; rresp = 2'b00;
    endtask

    task automatic beat(input logic [31:0] d, input logic [1:0] resp);
        rvalid = 1'b1; rlast = 1'b1; rdata = d; rresp = resp;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        #1;
        n_chk++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid got %b exp 0", arvalid); end
        n_chk++; if (araddr !== 32'd0) begin n_fail++; $display("FAIL reset_araddr got %h exp 0", araddr); end
        n_chk++; if (arsize !== 3'd0) begin n_fail++; $display("FAIL reset_arsize got %h exp 0", arsize); end
        n_chk++; if (rready !== 1'b1) begin n_fail++; $display("FAIL reset_rready got %b exp 1", rready); end
        n_chk++; if (dut.cnt_q !== 2'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", dut.cnt_q); end
        n_chk++; if ({addr_ok, data_ok} !== 2'b00) begin n_fail++; $display("FAIL reset_oks got %b exp 00", {addr_ok, data_ok}); end
        n_chk++; if ({arlen, arburst, arlock, arcache, arprot, arid} !== {8'd0, 2'b01, 2'b00, 4'd0, 3'd0, 4'd0})
            begin n_fail++; $display("FAIL ar_consts got %h", {arlen, arburst, arlock, arcache, arprot, arid}); end
    endtask

    // Minimum round trip: accept T, AR handshake T+1, data_ok T+2.
    task automatic test_single();
        step(); idle();
        req = 1'b1; addr = 32'hBFC0_0000; size = 2'd2; #1;
        n_chk++; if (addr_ok !== 1'b1) begin n_fail++; $display("FAIL single_addr_ok got %b exp 1", addr_ok); end
        if (addr_ok) exp_q.push_back(32'h3C1D_0010);
        step(); req = 1'b0; #1;
        n_chk++; if ({arvalid, araddr, arsize} !== {1'b1, 32'hBFC0_0000, 3'b010})
            begin n_fail++; $display("FAIL single_ar got %b %h %h exp 1 bfc00000 2", arvalid, araddr, arsize); end
        n_chk++; if (dut.cnt_q !== 2'd1) begin n_fail++; $display("FAIL single_cnt1 got %0d exp 1", dut.cnt_q); end
        step(); beat(32'h3C1D_0010, 2'b00); #1;
        n_chk++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL single_ar_clear got %b exp 0", arvalid); end
        exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        n_chk++; if (data_ok !== 1'b1 || sram_rdata !== exp_v)
            begin n_fail++; $display("FAIL single_data got ok=%b %h exp ok=1 %h", data_ok, sram_rdata, exp_v); end
        step(); idle(); #1;
        n_chk++; if (dut.cnt_q !== 2'd0) begin n_fail++; $display("FAIL single_cnt0 got %0d exp 0", dut.cnt_q); end
    endtask

    task automatic test_ar_backpressure();
        step(); idle();
        arready = 1'b0; req = 1'b1; addr = 32'h0000_1000; #1;
        n_chk++; if (addr_ok !== 1'b1) begin n_fail++; $display("FAIL bp_accept1 got %b exp 1", addr_ok); end
        if (addr_ok) exp_q.push_back(32'hAAAA_0001);
        for (int i = 0; i < 5; i++) begin
            step(); addr = 32'h0000_1004; #1;
            n_chk++; if ({arvalid, araddr, addr_ok} !== {1'b1, 32'h0000_1000, 1'b0})
                begin n_fail++; $display("FAIL bp_hold%0d got v=%b a=%h ok=%b exp 1 1000 0", i, arvalid, araddr, addr_ok); end
            if (i == 4) arready = 1'b1;
        end
        step(); #1;
        n_chk++; if ({arvalid, addr_ok} !== 2'b01) begin n_fail++; $display("FAIL bp_accept2 got %b exp 01", {arvalid, addr_ok}); end
        if (addr_ok) exp_q.push_back(32'hAAAA_0002);
        step(); req = 1'b0; #1;
        n_chk++; if ({arvalid, araddr} !== {1'b1, 32'h0000_1004}) begin n_fail++; $display("FAIL bp_ar2 got %b %h exp 1 1004", arvalid, araddr); end
        for (int i = 0; i < 2; i++) begin
            step(); beat(32'hAAAA_0001 + i, 2'b00); #1;
            exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            n_chk++; if (data_ok !== 1'b1 || sram_rdata !== exp_v)
                begin n_fail++; $display("FAIL bp_data%0d got ok=%b %h exp ok=1 %h", i, data_ok, sram_rdata, exp_v); end
        end
        step(); idle(); #1;
        n_chk++; if (dut.cnt_q !== 2'd0) begin n_fail++; $display("FAIL bp_cnt got %0d exp 0", dut.cnt_q); end
    endtask

    task automatic test_outstanding();
        step(); idle(); req = 1'b1; addr = 32'h0; #1;
        n_chk++; if (addr_ok !== 1'b1) begin n_fail++; $display("FAIL os_acc0 got %b exp 1", addr_ok); end
        if (addr_ok) exp_q.push_back(32'h0);
        step(); addr = 32'h4; #1;
        n_chk++; if (addr_ok !== 1'b0) begin n_fail++; $display("FAIL os_arbusy got %b exp 0", addr_ok); end
        step(); #1;
        n_chk++; if (addr_ok !== 1'b1) begin n_fail++; $display("FAIL os_acc4 got %b exp 1", addr_ok); end
        if (addr_ok) exp_q.push_back(32'h4);
        step(); addr = 32'h8; #1;
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            n_chk++; if ({addr_ok, dut.cnt_q} !== {1'b0, 2'd2})
                begin n_fail++; $display("FAIL os_full%0d got ok=%b cnt=%0d exp ok=0 cnt=2", i, addr_ok, dut.cnt_q); end
        end
        // Slot freed this cycle: data_ok but still no accept.
        step(); beat(32'h0, 2'b00); #1;
        exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        n_chk++; if ({data_ok, addr_ok} !== 2'b10 || sram_rdata !== exp_v)
            begin n_fail++; $display("FAIL os_free got dok=%b aok=%b %h exp 1 0 %h", data_ok, addr_ok, sram_rdata, exp_v); end
        step(); rvalid = 1'b0; rlast = 1'b0; #1;
        n_chk++; if (addr_ok !== 1'b1) begin n_fail++; $display("FAIL os_acc8 got %b exp 1", addr_ok); end
        if (addr_ok) exp_q.push_back(32'h8);
        for (int i = 0; i < 2; i++) begin
            step(); req = 1'b0; beat(32'h4 + 32'(4 * i), 2'b00); #1;
            exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            n_chk++; if (data_ok !== 1'b1 || sram_rdata !== exp_v)
                begin n_fail++; $display("FAIL os_data%0d got ok=%b %h exp ok=1 %h", i, data_ok, sram_rdata, exp_v); end
        end
        step(); idle(); #1;
        n_chk++; if (dut.cnt_q !== 2'd0 || exp_q.size() != 0)
            begin n_fail++; $display("FAIL os_drain got cnt=%0d q=%0d exp 0 0", dut.cnt_q, exp_q.size()); end
    endtask

    task automatic test_simultaneous();
        step(); idle(); req = 1'b1; addr = 32'h20; #1;
        if (addr_ok) exp_q.push_back(32'h1234);
        step(); req = 1'b0; #1;
        step(); req = 1'b1; addr = 32'h24; beat(32'h1234, 2'b10); #1;
        exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        n_chk++; if ({addr_ok, data_ok} !== 2'b11 || sram_rdata !== exp_v)
            begin n_fail++; $display("FAIL sim_both got aok=%b dok=%b %h exp 1 1 %h", addr_ok, data_ok, sram_rdata, exp_v); end
        if (addr_ok) exp_q.push_back(32'h5678);
        step(); idle(); #1;
        n_chk++; if ({dut.cnt_q, arvalid, araddr} !== {2'd1, 1'b1, 32'h24})
            begin n_fail++; $display("FAIL sim_state got cnt=%0d v=%b a=%h exp 1 1 24", dut.cnt_q, arvalid, araddr); end
        step(); beat(32'h5678, 2'b00); #1;
        exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        n_chk++; if (data_ok !== 1'b1 || sram_rdata !== exp_v)
            begin n_fail++; $display("FAIL sim_data2 got ok=%b %h exp ok=1 %h", data_ok, sram_rdata, exp_v); end
        step(); idle(); #1;
    endtask

    task automatic test_illegal_spurious();
        step(); idle(); req = 1'b1; wr = 1'b1; addr = 32'h40; #1;
        for (int i = 0; i < 4; i++) begin
            n_chk++; if ({addr_ok, arvalid} !== 2'b00)
                begin n_fail++; $display("FAIL wr_block%0d got aok=%b v=%b exp 0 0", i, addr_ok, arvalid); end
            step();
        end
        idle(); beat(32'hDEAD_BEEF, 2'b00); #1;
        n_chk++; if (data_ok !== 1'b0) begin n_fail++; $display("FAIL spurious_ok got %b exp 0", data_ok); end
        step(); idle(); #1;
        n_chk++; if (dut.cnt_q !== 2'd0) begin n_fail++; $display("FAIL spurious_cnt got %0d exp 0", dut.cnt_q); end
    endtask

    task automatic test_reset_midflight();
        step(); idle(); req = 1'b1; addr = 32'h100; #1;
        step(); req = 1'b0; #1;
        step(); req = 1'b1; addr = 32'h104; arready = 1'b0; #1;
        step(); req = 1'b0; #1;
        n_chk++; if ({arvalid, dut.cnt_q} !== {1'b1, 2'd2})
            begin n_fail++; $display("FAIL mid_pre got v=%b cnt=%0d exp 1 2", arvalid, dut.cnt_q); end
        reset = 1'b1;
        step(); reset = 1'b0; #1;
        n_chk++; if ({arvalid, dut.cnt_q} !== {1'b0, 2'd0})
            begin n_fail++; $display("FAIL mid_post got v=%b cnt=%0d exp 0 0", arvalid, dut.cnt_q); end
        beat(32'h0BAD_0BAD, 2'b00); #1;
        n_chk++; if (data_ok !== 1'b0) begin n_fail++; $display("FAIL mid_stale got %b exp 0", data_ok); end
        step(); idle(); #1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_ar_backpressure();
        test_outstanding();
        test_simultaneous();
        test_illegal_spurious();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
